priority_code_decoder: RTL and testbench



---
 rtl/priority_code_decoder.sv | 93 +++++++++
 tb/tb_priority_code_decoder.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/priority_code_decoder.sv
// priority_code_decoder: buffers {code,en} pairs in a FIFO and replays each code
// as a fixed-width one-hot pulse followed by an optional idle gap.
module priority_code_decoder #(
  parameter int PULSE_LEN = 4,
  parameter int GAP_LEN = 1,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [1:0]                 in_code,
  input  logic                       in_en,
  output logic [3:0]                 out_onehot,
  output logic                       out_busy,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic [7:0]                 null_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int MAXL = (PULSE_LEN > GAP_LEN ? PULSE_LEN : GAP_LEN) < 2 ? 2 :
                        (PULSE_LEN > GAP_LEN ? PULSE_LEN : GAP_LEN);
  localparam int CW = $clog2(MAXL);
  localparam logic [CW-1:0] PL1 = CW'(PULSE_LEN - 1);
  localparam logic [CW-1:0] GL1 = CW'(GAP_LEN > 0 ? GAP_LEN - 1 : 0);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [3:0] oh_nx;
  logic [1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic xfer, push, pop, empty;
  assign in_ready = fifo_count < FULL;
  assign xfer = in_valid && in_ready;
  assign push = xfer && in_en;
  assign empty = fifo_count == '0;
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    oh_nx = out_onehot;
    pop = 1'b0;
    case (state)
      IDLE: begin
        oh_nx = '0;
        pop = !empty;
      end
      PULSE:
        if (cnt != '0) cnt_nx = cnt - 1'b1;
        else if (GAP_LEN > 0) begin
          oh_nx = '0;
          cnt_nx = GL1;
          state_nx = GAP;
        end else if (!empty) pop = 1'b1;
        else begin
          oh_nx = '0;
          state_nx = IDLE;
        end
      GAP:
        if (cnt != '0) cnt_nx = cnt - 1'b1;
        else if (!empty) pop = 1'b1;
        else state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (pop) begin
      oh_nx = 4'b1 << mem[rp];
      cnt_nx = PL1;
      state_nx = PULSE;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      out_onehot <= '0;
      out_busy <= 1'b0;
      wp <= '0;
      rp <= '0;
      fifo_count <= '0;
      null_count <= '0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      out_onehot <= oh_nx;
      out_busy <= state_nx != IDLE;
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      fifo_count <= fifo_count + (AW+1)'(push) - (AW+1)'(pop);
      if (xfer && !in_en && null_count != 8'hff) null_count <= null_count + 1'b1;
    end
  // Storage needs no reset: the pointers and count flush it.
  always_ff @(posedge clk)
    if (push) mem[wp] <= in_code;
endmodule

// File: tb/tb_priority_code_decoder.sv
// tb_priority_code_decoder: two instances (default timing, and PULSE_LEN=1/GAP_LEN=0)
// checked every cycle against a pulse-timeline model plus hand-computed expectations.
module tb_priority_code_decoder;
  logic clk = 0, rst_n, in_valid, in_en;
  logic [1:0] in_code;
  logic [3:0] oh_a, oh_b;
  logic busy_a, busy_b, rdy_a, rdy_b;
  logic [2:0] fc_a, fc_b;
  logic [7:0] nc_a, nc_b;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  priority_code_decoder #(.PULSE_LEN(4), .GAP_LEN(1), .DEPTH(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_a), .in_code(in_code),
    .in_en(in_en), .out_onehot(oh_a), .out_busy(busy_a), .fifo_count(fc_a), .null_count(nc_a));
  priority_code_decoder #(.PULSE_LEN(1), .GAP_LEN(0), .DEPTH(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_b), .in_code(in_code),
    .in_en(in_en), .out_onehot(oh_b), .out_busy(busy_b), .fifo_count(fc_b), .null_count(nc_b));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Timeline model: each accepted code is assigned its pulse start edge at push time;
  // a pulse occupies PULSE_LEN edges and blocks the next start for PULSE_LEN+GAP_LEN.
  int pl[2] = '{4, 1};
  int gl[2] = '{1, 0};
  int n[2], st[2][8], cd[2][8], has[2], cs[2], cc[2], fa[2], nul[2];
  int cyc = 0;
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        n[d] = 0; has[d] = 0; nul[d] = 0; fa[d] = 0;
      end
    end else begin
      cyc++;
      for (int d = 0; d < 2; d++) begin
        bit acc;
        int s;
        acc = in_valid && n[d] < 4;
        if (n[d] > 0 && st[d][0] == cyc) begin
          cc[d] = cd[d][0]; cs[d] = cyc; has[d] = 1;
          for (int i = 0; i < 7; i++) begin
            st[d][i] = st[d][i+1]; cd[d][i] = cd[d][i+1];
          end
          n[d]--;
        end
        if (acc && !in_en && nul[d] < 255) nul[d]++;
        if (acc && in_en) begin
          s = (cyc + 1 > fa[d]) ? cyc + 1 : fa[d];
          st[d][n[d]] = s; cd[d][n[d]] = int'(in_code); n[d]++;
          fa[d] = s + pl[d] + gl[d];
        end
      end
    end
  end
  function automatic int exp_oh(int d);
    return (has[d] != 0 && cyc < cs[d] + pl[d]) ? (1 << cc[d]) : 0;
  endfunction
  function automatic int exp_busy(int d);
    return (has[d] != 0 && cyc < cs[d] + pl[d] + gl[d]) ? 1 : 0;
  endfunction

  always @(negedge clk)
    if (rst_n === 1'b1)
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("model_onehot%0d", d), d == 0 ? oh_a : oh_b, exp_oh(d));
        chk($sformatf("model_busy%0d", d), d == 0 ? busy_a : busy_b, exp_busy(d));
        chk($sformatf("model_count%0d", d), d == 0 ? fc_a : fc_b, n[d]);
        chk($sformatf("model_ready%0d", d), d == 0 ? rdy_a : rdy_b, n[d] < 4);
        chk($sformatf("model_null%0d", d), d == 0 ? nc_a : nc_b, nul[d]);
      end

  logic [3:0] ha[32], hb[32];
  logic bz[32];
  task automatic tick(input int k);
    @(negedge clk);
    ha[k] = oh_a; hb[k] = oh_b; bz[k] = busy_a;
  endtask

  int codes[5] = '{3, 2, 1, 0, 3};
  initial begin
    rst_n = 0; in_valid = 0; in_code = 0; in_en = 0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1;
    @(negedge clk);
    chk("rst_onehot", oh_a, 0);
    chk("rst_ready", rdy_a, 1);
    chk("rst_count", fc_a, 0);
    chk("rst_null", nc_a, 0);
    chk("rst_busy", busy_a, 0);
    // single code 2
    in_valid = 1; in_code = 2; in_en = 1;
    tick(0);
    in_valid = 0;
    for (int k = 1; k < 8; k++) tick(k);
    chk("single_n0", ha[0], 4'b0000);
    chk("single_n1", ha[1], 4'b0100);
    chk("single_n4", ha[4], 4'b0100);
    chk("single_gap", ha[5], 4'b0000);
    chk("single_busy_gap", bz[5], 1);
    chk("single_busy_end", bz[6], 0);
    chk("single_b1", hb[1], 4'b0100);
    chk("single_b2", hb[2], 4'b0000);
    // null codes
    in_valid = 1; in_en = 0; in_code = 3;
    @(negedge clk);
    in_valid = 0;
    chk("null_one", nc_a, 1);
    chk("null_count0", fc_a, 0);
    chk("null_onehot", oh_a, 0);
    in_valid = 1;
    repeat (300) @(negedge clk);
    in_valid = 0;
    chk("null_sat_a", nc_a, 255);
    chk("null_sat_b", nc_b, 255);
    // fill and back-pressure
    for (int k = 0; k < 5; k++) begin
      in_valid = 1; in_en = 1; in_code = 2'(codes[k]);
      tick(k);
    end
    in_valid = 0;
    chk("fill_count", fc_a, 4);
    chk("fill_ready", rdy_a, 0);
    for (int k = 5; k < 27; k++) tick(k);
    chk("fill_p0", ha[1], 4'b1000);
    chk("fill_p0_end", ha[4], 4'b1000);
    chk("fill_gap", ha[5], 4'b0000);
    chk("fill_p1", ha[6], 4'b0100);
    chk("fill_p2", ha[11], 4'b0010);
    chk("fill_p3", ha[16], 4'b0001);
    chk("fill_p4", ha[21], 4'b1000);
    chk("fill_done", ha[25], 4'b0000);
    chk("b2b_0", hb[1], 4'b1000);
    chk("b2b_1", hb[2], 4'b0100);
    chk("b2b_2", hb[3], 4'b0010);
    chk("b2b_3", hb[4], 4'b0001);
    chk("b2b_4", hb[5], 4'b1000);
    chk("b2b_end", hb[6], 4'b0000);
    // no-gap back-to-back codes 0,1
    in_valid = 1; in_en = 1; in_code = 0;
    tick(0);
    in_code = 1;
    tick(1);
    in_valid = 0;
    tick(2);
    tick(3);
    chk("nogap_0", hb[1], 4'b0001);
    chk("nogap_1", hb[2], 4'b0010);
    chk("nogap_end", hb[3], 4'b0000);
    repeat (12) @(negedge clk);
    // reset in the 2nd cycle of a 1000 pulse with two codes queued
    for (int k = 0; k < 3; k++) begin
      in_valid = 1; in_en = 1; in_code = 2'(codes[k]);
      tick(k);
    end
    in_valid = 0;
    chk("mid_pulse", ha[2], 4'b1000);
    chk("mid_queued", fc_a, 2);
    #1 rst_n = 0;
    #1;
    chk("mid_rst_onehot", oh_a, 0);
    chk("mid_rst_count", fc_a, 0);
    chk("mid_rst_busy", busy_a, 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1;
    for (int k = 0; k < 8; k++) tick(k);
    chk("no_resume_1", ha[1], 0);
    chk("no_resume_5", ha[5], 0);
    chk("no_resume_count", fc_a, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
